// File: rtl/speck_adder_arbiter.sv
// One WIDTH-bit modular adder shared by two requesters under round-robin arbitration.
// Each accepted operation (a+b or a+1) lands in a single registered result slot with backpressure.
module speck_adder_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             trigger,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_inc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_inc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             last_id;
  logic             slot_free;
  logic             accept0;
  logic             accept1;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_inc;
  logic [WIDTH:0]   sum;

  assign slot_free = !rsp_valid || rsp_ready;

  // On a tie the requester that did not win last time is granted; rst_n gates both readys.
  assign req0_ready = rst_n && slot_free && req0_valid && (!req1_valid || last_id);
  assign req1_ready = rst_n && slot_free && req1_valid && (!req0_valid || !last_id);

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;

  always_comb begin
    op_a   = req0_a;
    op_b   = req0_b;
    op_inc = req0_inc;
    if (accept1) begin
      op_a   = req1_a;
      op_b   = req1_b;
      op_inc = req1_inc;
    end
  end

  assign sum = {1'b0, op_a} + {1'b0, (op_inc ? ONE : op_b)};

  // Payload registers keep their value on a plain drain; only rsp_valid drops.
  always_ff @(posedge trigger or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_carry <= 1'b0;
      last_id   <= 1'b1;
    end else if (accept0 || accept1) begin
      rsp_valid <= 1'b1;
      rsp_data  <= sum[WIDTH-1:0];
      rsp_carry <= sum[WIDTH];
      rsp_id    <= accept1;
      last_id   <= accept1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_speck_adder_arbiter.sv
// Directed and randomized checks of speck_adder_arbiter against a queue-based
// reference model: each requester's expected sums are consumed in issue order.
module tb_speck_adder_arbiter;

  logic        trigger = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_inc;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_inc;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carry;
  logic [31:0] rsp_data;

  int assert_count = 0;
  int fail_count   = 0;

  speck_adder_arbiter #(.WIDTH(32)) dut (
    .trigger    (trigger),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_inc   (req0_inc),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_inc   (req1_inc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry)
  );

  always #5 trigger = ~trigger;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b,
                                          input logic inc);
    return {1'b0, a} + (inc ? 33'd1 : {1'b0, b});
  endfunction

  task automatic set_req(input int n, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic inc);
    if (n == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_inc = inc;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_inc = inc;
    end
  endtask

  initial begin
    int          k0, k1, issued, cycles;
    logic [31:0] held;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [32:0] exp_sum;
    logic        m_valid, m_id, m_last, sf, g0, g1;
    logic [31:0] ra, rb;
    logic        rinc;

    // Reset state, with req0 already asking so ready must be suppressed.
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'd5, 32'd7, 1'b0);
    set_req(1, 1'b0, 32'd0, 32'd0, 1'b0);
    #2;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data",  64'(rsp_data),  64'd0);
    check("reset_rsp_id",    64'(rsp_id),    64'd0);
    check("reset_rsp_carry", 64'(rsp_carry), 64'd0);
    check("reset_ready0",    64'(req0_ready), 64'd0);
    check("reset_ready1",    64'(req1_ready), 64'd0);

    // Single req0 5+7.
    @(negedge trigger);
    rst_n = 1'b1;
    #1;
    check("single_ready0", 64'(req0_ready), 64'd1);
    check("single_ready1", 64'(req1_ready), 64'd0);
    @(posedge trigger); #1;
    set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
    check("single_valid", 64'(rsp_valid), 64'd1);
    check("single_id",    64'(rsp_id),    64'd0);
    check("single_data",  64'(rsp_data),  64'd12);
    check("single_carry", 64'(rsp_carry), 64'd0);

    // Overflow add on req0, then increment wrap on req1.
    @(negedge trigger);
    set_req(0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    #1;
    check("ovf_ready0", 64'(req0_ready), 64'd1);
    @(posedge trigger); #1;
    set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
    check("ovf_data",  64'(rsp_data),  64'd0);
    check("ovf_carry", 64'(rsp_carry), 64'd1);
    check("ovf_id",    64'(rsp_id),    64'd0);

    @(negedge trigger);
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    #1;
    check("wrap_ready1", 64'(req1_ready), 64'd1);
    @(posedge trigger); #1;
    set_req(1, 1'b0, 32'd0, 32'd0, 1'b0);
    check("wrap_data",  64'(rsp_data),  64'd0);
    check("wrap_carry", 64'(rsp_carry), 64'd1);
    check("wrap_id",    64'(rsp_id),    64'd1);

    // Both valid for four cycles: grants alternate starting with req0.
    k0 = 0; k1 = 0; held = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge trigger);
      set_req(0, 1'b1, 32'(100 + k0), 32'd3, 1'b0);
      set_req(1, 1'b1, 32'(1000 + k1), 32'd9, 1'b1);
      #1;
      check("rr_ready0", 64'(req0_ready), 64'(i % 2 == 0));
      check("rr_ready1", 64'(req1_ready), 64'(i % 2 == 1));
      @(posedge trigger); #1;
      check("rr_id", 64'(rsp_id), 64'(i % 2));
      if (i % 2 == 0) begin
        check("rr_data0", 64'(rsp_data), 64'(103 + k0));
        k0++;
      end else begin
        held = 32'(1001 + k1);
        check("rr_data1", 64'(rsp_data), 64'(held));
        k1++;
      end
    end

    // Backpressure with both still valid.
    for (int j = 0; j < 3; j++) begin
      @(negedge trigger);
      rsp_ready = 1'b0;
      set_req(0, 1'b1, 32'(100 + k0), 32'd3, 1'b0);
      set_req(1, 1'b1, 32'(1000 + k1), 32'd9, 1'b1);
      #1;
      check("bp_ready0", 64'(req0_ready), 64'd0);
      check("bp_ready1", 64'(req1_ready), 64'd0);
      @(posedge trigger); #1;
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_data",  64'(rsp_data),  64'(held));
      check("bp_id",    64'(rsp_id),    64'd1);
    end
    @(negedge trigger);
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready0", 64'(req0_ready), 64'd1);
    check("bp_release_ready1", 64'(req1_ready), 64'd0);
    @(posedge trigger); #1;
    check("bp_release_valid", 64'(rsp_valid), 64'd1);
    check("bp_release_id",    64'(rsp_id),    64'd0);
    check("bp_release_data",  64'(rsp_data),  64'(103 + k0));
    k0++;

    // Asynchronous reset mid-cycle while a result is held.
    @(negedge trigger);
    set_req(0, 1'b1, 32'(100 + k0), 32'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_valid",  64'(rsp_valid),  64'd0);
    check("areset_data",   64'(rsp_data),   64'd0);
    check("areset_ready0", 64'(req0_ready), 64'd0);
    check("areset_ready1", 64'(req1_ready), 64'd0);
    @(negedge trigger);
    rst_n = 1'b1;
    #1;
    check("post_reset_ready0", 64'(req0_ready), 64'd1);
    check("post_reset_ready1", 64'(req1_ready), 64'd0);
    @(posedge trigger); #1;
    check("post_reset_id",    64'(rsp_id),    64'd0);
    check("post_reset_valid", 64'(rsp_valid), 64'd1);
    check("post_reset_data",  64'(rsp_data),  64'(103 + k0));

    // Drain without accept: valid drops, payload holds.
    @(negedge trigger);
    set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
    set_req(1, 1'b0, 32'd0, 32'd0, 1'b0);
    @(posedge trigger); #1;
    check("drain_valid", 64'(rsp_valid), 64'd0);
    check("drain_data",  64'(rsp_data),  64'(103 + k0));
    check("drain_id",    64'(rsp_id),    64'd0);

    // Randomized traffic against the reference model.
    m_valid = 1'b0; m_id = 1'b0; m_last = 1'b0;
    issued = 0; cycles = 0;
    while ((issued < 10000 || q0.size() != 0 || q1.size() != 0) && cycles < 60000) begin
      @(negedge trigger);
      cycles++;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int n = 0; n < 2; n++) begin
        if (((n == 0) ? !req0_valid : !req1_valid) && issued < 10000 &&
            $urandom_range(0, 3) != 0) begin
          ra   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
          rb   = $urandom;
          rinc = 1'($urandom_range(0, 1));
          set_req(n, 1'b1, ra, rb, rinc);
          if (n == 0) q0.push_back(ref_sum(ra, rb, rinc));
          else        q1.push_back(ref_sum(ra, rb, rinc));
          issued++;
        end
      end
      #1;
      sf = !m_valid || rsp_ready;
      g0 = sf && req0_valid && (!req1_valid || m_last);
      g1 = sf && req1_valid && (!req0_valid || !m_last);
      check("rand_ready0", 64'(req0_ready), 64'(g0));
      check("rand_ready1", 64'(req1_ready), 64'(g1));
      check("rand_valid",  64'(rsp_valid),  64'(m_valid));
      if (m_valid && rsp_ready) begin
        check("rand_id", 64'(rsp_id), 64'(m_id));
        if (m_id == 1'b0 && q0.size() != 0) exp_sum = q0.pop_front();
        else if (m_id == 1'b1 && q1.size() != 0) exp_sum = q1.pop_front();
        else exp_sum = 33'h1_FFFF_FFFF;
        check("rand_sum", 64'({rsp_carry, rsp_data}), 64'(exp_sum));
      end
      @(posedge trigger); #1;
      if (g0) begin
        m_valid = 1'b1; m_id = 1'b0; m_last = 1'b0; req0_valid = 1'b0;
      end else if (g1) begin
        m_valid = 1'b1; m_id = 1'b1; m_last = 1'b1; req1_valid = 1'b0;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
    check("rand_timeout", 64'(cycles < 60000), 64'd1);
    check("rand_q0_empty", 64'(q0.size()), 64'd0);
    check("rand_q1_empty", 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
